// File: rtl/key_debouncer.sv
// ============================================================================
// Module   : key_debouncer
// Purpose  : Per-channel two-flop synchronizer plus counting debouncer for
//            raw front-panel keys; presents clean levels to the edge detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer #(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 2_000_000,
  parameter int CW            = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] settling,
  output logic                any_settling
);

  typedef enum logic {
    ST_STABLE    = 1'b0,
    ST_CANDIDATE = 1'b1
  } state_e;

  localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    logic          level_q;
    logic          level_d;
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        state_q <= ST_STABLE;
        cnt_q   <= '0;
      end else begin
        s1_q    <= raw_in[i];
        s2_q    <= s1_q;
        level_q <= level_d;
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Any sample matching the current level aborts the candidate, so a
    // bounce restarts the count from one on the next mismatch.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      case (state_q)
        ST_STABLE: begin
          if (s2_q != level_q) begin
            state_d = ST_CANDIDATE;
            cnt_d   = C_CNT_ONE;
          end
        end
        ST_CANDIDATE: begin
          if (s2_q == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == C_CNT_LAST) begin
            level_d = s2_q;
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + C_CNT_ONE;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign level_out[i] = level_q;
    assign settling[i]  = (state_q == ST_CANDIDATE);
  end

  assign any_settling = |settling;

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
// ============================================================================
// Module   : tb_key_debouncer
// Purpose  : Directed bench for key_debouncer (STABLE_CYCLES = 4 and 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       rst_a;
  logic [4:0] raw_a;
  logic [4:0] level_a;
  logic [4:0] settling_a;
  logic       any_a;
  logic       rst_b;
  logic [4:0] raw_b;
  logic [4:0] level_b;
  logic [4:0] settling_b;
  logic       any_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debouncer #(.CHANNELS(5), .STABLE_CYCLES(4)) dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .raw_in       (raw_a),
    .level_out    (level_a),
    .settling     (settling_a),
    .any_settling (any_a)
  );

  key_debouncer #(.CHANNELS(5), .STABLE_CYCLES(8)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .raw_in       (raw_b),
    .level_out    (level_b),
    .settling     (settling_b),
    .any_settling (any_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [4:0] lvl, input logic [4:0] stl);
    chk({tag, "_level"}, level_a, lvl);
    chk({tag, "_settling"}, settling_a, stl);
    chk({tag, "_any"}, {4'b0, any_a}, {4'b0, |stl});
  endtask

  initial begin
    rst_a = 1'b1;
    raw_a = 5'b11111;
    rst_b = 1'b1;
    raw_b = 5'b00000;

    // Reset held for three edges with all keys pressed.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_a("rst_hold", 5'b00000, 5'b00000);
    end

    // Release: first edge with rst=0 is t1; level rises after t6.
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();
    tick();
    chk_a("rel_t2", 5'b00000, 5'b00000);
    tick();
    chk_a("rel_t3", 5'b00000, 5'b11111);
    tick();
    tick();
    chk_a("rel_t5", 5'b00000, 5'b11111);
    tick();
    chk_a("rel_t6", 5'b11111, 5'b00000);

    raw_a = 5'b00000;
    repeat (7) tick();
    chk_a("rel_fall", 5'b00000, 5'b00000);

    // Clean press on channel 0.
    raw_a[0] = 1'b1;
    tick();
    tick();
    chk_a("press_t2", 5'b00000, 5'b00000);
    tick();
    chk_a("press_t3", 5'b00000, 5'b00001);
    tick();
    tick();
    chk_a("press_t5", 5'b00000, 5'b00001);
    tick();
    chk_a("press_t6", 5'b00001, 5'b00000);
    raw_a[0] = 1'b0;
    repeat (7) tick();
    chk_a("press_fall", 5'b00000, 5'b00000);

    // Single-cycle glitch on channel 1.
    raw_a[1] = 1'b1;
    tick();
    raw_a[1] = 1'b0;
    tick();
    chk_a("glitch_t2", 5'b00000, 5'b00000);
    tick();
    chk_a("glitch_t3", 5'b00000, 5'b00010);
    tick();
    chk_a("glitch_t4", 5'b00000, 5'b00000);
    repeat (6) tick();
    chk_a("glitch_end", 5'b00000, 5'b00000);

    // Bounce on channel 2: 1,0,1,0 for two cycles each, then held high.
    for (int p = 0; p < 4; p++) begin
      raw_a[2] = (p % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      chk("bounce_level", level_a, 5'b00000);
      tick();
      chk("bounce_level", level_a, 5'b00000);
    end
    raw_a[2] = 1'b1;
    repeat (5) tick();
    chk("bounce_t5_level", level_a, 5'b00000);
    tick();
    chk_a("bounce_t6", 5'b00100, 5'b00000);
    raw_a[2] = 1'b0;
    repeat (7) tick();
    chk_a("bounce_fall", 5'b00000, 5'b00000);

    // Parallel activity: channel 0 before t1, channel 4 before t3.
    raw_a[0] = 1'b1;
    tick(); chk_a("par_t1", 5'b00000, 5'b00000);
    tick(); chk_a("par_t2", 5'b00000, 5'b00000);
    raw_a[4] = 1'b1;
    tick(); chk_a("par_t3", 5'b00000, 5'b00001);
    tick(); chk_a("par_t4", 5'b00000, 5'b00001);
    tick(); chk_a("par_t5", 5'b00000, 5'b10001);
    tick(); chk_a("par_t6", 5'b00001, 5'b10000);
    tick(); chk_a("par_t7", 5'b00001, 5'b10000);
    tick(); chk_a("par_t8", 5'b10001, 5'b00000);
    repeat (12) tick();
    raw_a[0] = 1'b0;
    tick(); chk_a("par_u1", 5'b10001, 5'b00000);
    tick(); chk_a("par_u2", 5'b10001, 5'b00000);
    tick(); chk_a("par_u3", 5'b10001, 5'b00001);
    tick(); chk_a("par_u4", 5'b10001, 5'b00001);
    tick(); chk_a("par_u5", 5'b10001, 5'b00001);
    tick(); chk_a("par_u6", 5'b10000, 5'b00000);

    // Reset mid-count on the S=8 instance, channel 3.
    raw_b[3] = 1'b1;
    repeat (5) tick();
    chk("mid_t5_settling", settling_b, 5'b01000);
    chk("mid_t5_level", level_b, 5'b00000);
    rst_b = 1'b1;
    tick();
    chk("mid_rst_settling", settling_b, 5'b00000);
    chk("mid_rst_level", level_b, 5'b00000);
    chk("mid_rst_any", {4'b0, any_b}, 5'b00000);
    rst_b = 1'b0;
    repeat (9) tick();
    chk("mid_r9_level", level_b, 5'b00000);
    chk("mid_r9_settling", settling_b, 5'b01000);
    tick();
    chk("mid_r10_level", level_b, 5'b01000);
    chk("mid_r10_settling", settling_b, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
